// File: rtl/slot_sequence_monitor.sv
// Receive-side checker for a four-slot round-robin scheduler: tracks slot order,
// burst dwell and idle-gap length, and reports sync, rounds and violations.
module slot_sequence_monitor #(
  parameter int DWELL0  = 1,
  parameter int DWELL1  = 2,
  parameter int DWELL2  = 3,
  parameter int DWELL3  = 4,
  parameter int MAX_GAP = 2,
  parameter int CW      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] en_in,
  output logic [1:0] cur_slot,
  output logic       in_sync,
  output logic       err_pulse,
  output logic [2:0] err_code,
  output logic [7:0] round_cnt,
  output logic [7:0] err_cnt
);

  typedef enum logic [1:0] {IDLE, HUNT, ACTIVE, GAP} state_t;

  localparam logic [2:0] E_MULTI = 3'd1;
  localparam logic [2:0] E_ORDER = 3'd2;
  localparam logic [2:0] E_SHORT = 3'd3;
  localparam logic [2:0] E_LONG  = 3'd4;
  localparam logic [2:0] E_GAP   = 3'd5;

  state_t        state, state_nxt;
  logic [CW-1:0] c, c_nxt, g, g_nxt;
  logic [1:0]    slot_nxt;
  logic          sync_nxt, pulse_nxt;
  logic [2:0]    code_nxt;
  logic [7:0]    round_nxt, errc_nxt;

  logic          err_hit;
  logic [2:0]    err_val;
  logic [3:0]    own_hot, next_hot;
  logic          multi_hot;
  logic [CW-1:0] dwell;

  function automatic logic [CW-1:0] dwell_of(input logic [1:0] s);
    case (s)
      2'd0:    return CW'(DWELL0);
      2'd1:    return CW'(DWELL1);
      2'd2:    return CW'(DWELL2);
      default: return CW'(DWELL3);
    endcase
  endfunction

  // cur_slot doubles as the slot register s; it is forced to 0 in IDLE/HUNT.
  assign own_hot   = 4'b0001 << cur_slot;
  assign next_hot  = 4'b0001 << (cur_slot + 2'd1);
  assign multi_hot = (en_in & (en_in - 4'd1)) != 4'd0;
  assign dwell     = dwell_of(cur_slot);

  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    c_nxt     = c;
    g_nxt     = g;
    slot_nxt  = cur_slot;
    sync_nxt  = in_sync;
    pulse_nxt = 1'b0;
    code_nxt  = err_code;
    round_nxt = round_cnt;
    errc_nxt  = err_cnt;
    err_hit   = 1'b0;
    err_val   = 3'd0;

    if (!enable) begin
      state_nxt = IDLE;
      slot_nxt  = 2'd0;
      sync_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: state_nxt = HUNT;
        HUNT: begin
          if (en_in == 4'b0001) begin
            state_nxt = ACTIVE;
            slot_nxt  = 2'd0;
            c_nxt     = CW'(1);
          end else if (multi_hot) begin
            err_hit = 1'b1;
            err_val = E_MULTI;
          end
        end
        ACTIVE: begin
          if (en_in == own_hot) begin
            if (c < dwell) c_nxt = c + CW'(1);
            else begin err_hit = 1'b1; err_val = E_LONG; end
          end else if (en_in == 4'd0) begin
            if (c >= dwell) begin
              state_nxt = GAP;
              g_nxt     = CW'(1);
              slot_nxt  = cur_slot + 2'd1;
              sync_nxt  = 1'b1;
              if (cur_slot == 2'd3) round_nxt = round_cnt + 8'd1;
            end else begin
              err_hit = 1'b1;
              err_val = E_SHORT;
            end
          end else if (en_in == next_hot && c >= dwell) begin
            // Zero-gap handoff: close this burst and open the next one at once.
            c_nxt    = CW'(1);
            slot_nxt = cur_slot + 2'd1;
            sync_nxt = 1'b1;
            if (cur_slot == 2'd3) round_nxt = round_cnt + 8'd1;
          end else begin
            err_hit = 1'b1;
            err_val = multi_hot ? E_MULTI : E_ORDER;
          end
        end
        GAP: begin
          if (en_in == 4'd0) begin
            if (g < CW'(MAX_GAP)) g_nxt = g + CW'(1);
            else begin err_hit = 1'b1; err_val = E_GAP; end
          end else if (en_in == own_hot) begin
            state_nxt = ACTIVE;
            c_nxt     = CW'(1);
          end else begin
            err_hit = 1'b1;
            err_val = multi_hot ? E_MULTI : E_ORDER;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    if (err_hit) begin
      state_nxt = HUNT;
      slot_nxt  = 2'd0;
      sync_nxt  = 1'b0;
      pulse_nxt = 1'b1;
      code_nxt  = err_val;
      errc_nxt  = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      c         <= '0;
      g         <= '0;
      cur_slot  <= 2'd0;
      in_sync   <= 1'b0;
      err_pulse <= 1'b0;
      err_code  <= 3'd0;
      round_cnt <= 8'd0;
      err_cnt   <= 8'd0;
    end else begin
      state     <= state_nxt;
      c         <= c_nxt;
      g         <= g_nxt;
      cur_slot  <= slot_nxt;
      in_sync   <= sync_nxt;
      err_pulse <= pulse_nxt;
      err_code  <= code_nxt;
      round_cnt <= round_nxt;
      err_cnt   <= errc_nxt;
    end
  end

endmodule

// File: tb/tb_slot_sequence_monitor.sv
// Scoreboard bench for slot_sequence_monitor: a behavioural model pushes the
// expected output word per driven sample; it is popped and compared after the edge.
module tb_slot_sequence_monitor;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] en_in;
  logic [1:0] cur_slot;
  logic       in_sync;
  logic       err_pulse;
  logic [2:0] err_code;
  logic [7:0] round_cnt;
  logic [7:0] err_cnt;

  slot_sequence_monitor dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .en_in     (en_in),
    .cur_slot  (cur_slot),
    .in_sync   (in_sync),
    .err_pulse (err_pulse),
    .err_code  (err_code),
    .round_cnt (round_cnt),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: 0 idle, 1 hunt, 2 active, 3 gap.
  int m_state, m_s, m_c, m_g, m_code, m_round, m_errc;
  bit m_sync, m_pulse;
  int dw[4] = '{1, 2, 3, 4};
  localparam int MGAP = 2;

  logic [22:0] exp_q[$];

  task automatic model_reset();
    m_state = 0; m_s = 0; m_c = 0; m_g = 0;
    m_code = 0; m_round = 0; m_errc = 0;
    m_sync = 0; m_pulse = 0;
  endtask

  task automatic finish_burst();
    if (m_s == 3) m_round = (m_round + 1) % 256;
    m_s = (m_s + 1) % 4;
    m_sync = 1;
  endtask

  task automatic model_step(input logic ena, input logic [3:0] e);
    int err;
    int ones;
    int nxt;
    err = 0;
    ones = $countones(e);
    nxt = (m_s + 1) % 4;
    m_pulse = 0;
    if (!ena) begin
      m_state = 0; m_sync = 0; m_s = 0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (ones > 1) err = 1;
      else if (e == 4'b0001) begin m_state = 2; m_s = 0; m_c = 1; end
    end else if (m_state == 2) begin
      if (ones > 1) err = 1;
      else if (ones == 0) begin
        if (m_c == dw[m_s]) begin finish_burst(); m_state = 3; m_g = 1; end
        else err = 3;
      end else if (e[m_s]) begin
        if (m_c == dw[m_s]) err = 4; else m_c++;
      end else if (e[nxt] && m_c == dw[m_s]) begin
        finish_burst(); m_c = 1;
      end else err = 2;
    end else begin
      if (ones > 1) err = 1;
      else if (ones == 0) begin
        if (m_g == MGAP) err = 5; else m_g++;
      end else if (e[m_s]) begin m_state = 2; m_c = 1; end
      else err = 2;
    end
    if (err != 0) begin
      m_state = 1; m_s = 0; m_sync = 0; m_pulse = 1; m_code = err;
      if (m_errc < 255) m_errc++;
    end
  endtask

  function automatic logic [22:0] model_word();
    return {2'(m_s), m_sync, m_pulse, 3'(m_code), 8'(m_round), 8'(m_errc)};
  endfunction

  task automatic cyc(input logic ena, input logic [3:0] e);
    logic [22:0] got;
    enable = ena;
    en_in  = e;
    model_step(ena, e);
    exp_q.push_back(model_word());
    @(posedge clk);
    #1;
    got = {cur_slot, in_sync, err_pulse, err_code, round_cnt, err_cnt};
    check("cyc", 32'(got), 32'(exp_q.pop_front()));
  endtask

  task automatic burst(input int slot, input int len);
    for (int i = 0; i < len; i++) cyc(1'b1, 4'(1 << slot));
  endtask

  task automatic zeros(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 4'b0000);
  endtask

  task automatic nominal_round();
    burst(0, 1); zeros(1);
    burst(1, 2); zeros(1);
    burst(2, 3); zeros(1);
    burst(3, 4); zeros(1);
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    exp_q.delete();
    check({tag, "_out"}, 32'({cur_slot, in_sync, err_pulse, err_code}), 32'd0);
    check({tag, "_cnt"}, 32'({round_cnt, err_cnt}), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; en_in = 4'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'({cur_slot, in_sync, err_pulse, err_code}), 32'd0);
    check("rst_cnt", 32'({round_cnt, err_cnt}), 32'd0);
    reset = 1'b0;

    // Nominal: three rounds, sync after the first closing zero.
    cyc(1'b1, 4'b0000);
    burst(0, 1);
    check("pre_sync", 32'(in_sync), 32'd0);
    zeros(1);
    check("sync_up", 32'(in_sync), 32'd1);
    zeros(0);
    burst(1, 2); zeros(1); burst(2, 3); zeros(1); burst(3, 4); zeros(1);
    nominal_round();
    nominal_round();
    check("round3", 32'(round_cnt), 32'd3);
    check("noerr", 32'(err_cnt), 32'd0);

    // Zero gap after slot0, max gap after slot1.
    burst(0, 1); burst(1, 2); zeros(2); burst(2, 3); zeros(1); burst(3, 4); zeros(1);
    check("gap_round", 32'(round_cnt), 32'd4);
    check("gap_noerr", 32'(err_cnt), 32'd0);
    // Gap of three after slot2.
    burst(0, 1); zeros(1); burst(1, 2); zeros(1); burst(2, 3); zeros(3);
    check("gap_code", 32'(err_code), 32'd5);
    check("gap_errc", 32'(err_cnt), 32'd1);
    check("gap_sync", 32'(in_sync), 32'd0);

    // Short slot2, then long slot3.
    burst(0, 1); zeros(1); burst(1, 2); zeros(1); burst(2, 2); zeros(1);
    check("short", 32'(err_code), 32'd3);
    burst(0, 1); zeros(1); burst(1, 2); zeros(1); burst(2, 3); zeros(1); burst(3, 5);
    check("long", 32'(err_code), 32'd4);
    check("long_pulse", 32'(err_pulse), 32'd1);
    check("dwell_errc", 32'(err_cnt), 32'd3);

    // Order, multi-hot, tolerated stray single-hot, back-to-back errors.
    burst(0, 1); burst(2, 1);
    check("order", 32'(err_code), 32'd2);
    cyc(1'b1, 4'b0011);
    check("multi", 32'(err_code), 32'd1);
    burst(2, 1);
    check("stray", 32'(err_pulse), 32'd0);
    cyc(1'b1, 4'b1100);
    cyc(1'b1, 4'b0110);
    check("b2b_pulse", 32'(err_pulse), 32'd1);
    check("b2b_errc", 32'(err_cnt), 32'd7);

    // Async reset mid slot2 burst.
    burst(0, 1); zeros(1); burst(1, 2); zeros(1); burst(2, 2);
    do_reset("midrst");

    // Enable dropped mid slot1.
    cyc(1'b1, 4'b0000);
    nominal_round();
    cyc(1'b1, 4'b0011);
    burst(0, 1); zeros(1); burst(1, 1);
    cyc(1'b0, 4'b0010);
    check("dis_pulse", 32'(err_pulse), 32'd0);
    check("dis_cnt", 32'({round_cnt, err_cnt}), 32'h0101);
    cyc(1'b1, 4'b0010);
    cyc(1'b1, 4'b0010);
    burst(0, 1);
    check("rehunt", 32'({cur_slot, in_sync}), 32'd0);
    zeros(1);
    check("rehunt_sync", 32'(in_sync), 32'd1);

    // Error counter saturation.
    for (int i = 0; i < 256; i++) cyc(1'b1, 4'b0011);
    check("err_sat", 32'(err_cnt), 32'd255);

    // Round counter wrap.
    do_reset("wraprst");
    cyc(1'b1, 4'b0000);
    for (int i = 0; i < 257; i++) nominal_round();
    check("round_wrap", 32'(round_cnt), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
